mult_div_unit: RTL and testbench

Execute-stage multiply/divide unit of the pipelined MIPS CPU. It owns the HI/LO registers and generates the Busy signal the hazard unit consumes: it reads Start and op, and the hazard unit stalls on Start_E|Busy_E. It runs mult/multu/div/divu with fixed multi-cycle latency, services mthi/mtlo writes, and supplies mfhi/mflo read data to the E-stage result mux.

---
 rtl/mult_div_unit.sv | 82 ++++++++
 tb/tb_mult_div_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage HI/LO multiply/divide unit; ports clk, reset, Start, MDOp, A, B, ReadHI -> Busy, HI, LO, MDOut
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadHI,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic pend_wr;
  logic go, done, is_mult, sx, neg_a, neg_b;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, q, r, res_hi, res_lo;
  logic res_wr;
  always_comb begin
    go = Start && MDOp >= 3'd1 && MDOp <= 3'd4;
    done = cnt == CW'(1);
    is_mult = MDOp == 3'd1 || MDOp == 3'd2;
    sx = MDOp == 3'd1;
    // 64-bit multiply of sign/zero-extended operands gives the exact signed or unsigned product
    prod = {{32{sx & A[31]}}, A} * {{32{sx & B[31]}}, B};
    // signed divide done on magnitudes so 0x80000000 / -1 wraps instead of overflowing
    neg_a = MDOp == 3'd3 && A[31];
    neg_b = MDOp == 3'd3 && B[31];
    mag_a = neg_a ? -A : A;
    mag_b = neg_b ? -B : B;
    div_b = mag_b == 32'd0 ? 32'd1 : mag_b;
    uq = mag_a / div_b;
    ur = mag_a % div_b;
    q = (neg_a ^ neg_b) ? -uq : uq;
    r = neg_a ? -ur : ur;
    res_hi = is_mult ? prod[63:32] : r;
    res_lo = is_mult ? prod[31:0] : q;
    res_wr = is_mult || B != 32'd0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (go ? RUN : IDLE) : (done ? IDLE : RUN);
  always_comb begin
    Busy = state == RUN;
    MDOut = ReadHI ? HI : LO;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        cnt <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end
      if (MDOp == 3'd5) HI <= A;
      if (MDOp == 3'd6) LO <= A;
    end else begin
      cnt <= cnt - CW'(1);
      if (done && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clk = 0, reset = 1, Start = 0, ReadHI = 0;
  logic [2:0] MDOp = 0;
  logic [31:0] A = 0, B = 0;
  logic Busy;
  logic [31:0] HI, LO, MDOut;
  int checks = 0, passes = 0;
  localparam int MC = 5, DC = 10;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .ReadHI(ReadHI), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l, output logic w);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    h = 0; l = 0; w = 1;
    if (op == 3'd1) begin
      p = 64'(sa * sb);
      h = p[63:32]; l = p[31:0];
    end else if (op == 3'd2) begin
      p = {32'b0, a} * {32'b0, b};
      h = p[63:32]; l = p[31:0];
    end else if (b == 0) w = 0;
    else if (op == 3'd3) begin
      l = 32'(sa / sb); h = 32'(sa % sb);
    end else begin
      l = 32'(ua / ub); h = 32'(ua % ub);
    end
  endfunction

  logic [31:0] m_hi, m_lo, m_phi, m_plo, c_hi, c_lo;
  logic m_pw, c_w;
  int m_left;
  always_comb calc(MDOp, A, B, c_hi, c_lo, c_w);

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_left <= 0; m_pw <= 0; m_phi <= 0; m_plo <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pw) begin
        m_hi <= m_phi; m_lo <= m_plo;
      end
    end else begin
      if (Start && MDOp >= 1 && MDOp <= 4) begin
        m_left <= (MDOp <= 2) ? MC : DC;
        m_phi <= c_hi; m_plo <= c_lo; m_pw <= c_w;
      end
      if (MDOp == 5) m_hi <= A;
      if (MDOp == 6) m_lo <= A;
    end

  always @(negedge clk)
    if (!reset) begin
      check("busy", 32'(Busy), 32'(m_left > 0));
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("mdout", MDOut, ReadHI ? m_hi : m_lo);
    end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1; MDOp = op; A = a; B = b;
    #1 check("busy_in_start_cycle", 32'(Busy), 0);
    @(negedge clk); #1;
    Start = 0; MDOp = 0; A = ~a; B = $urandom;
  endtask

  task automatic finish_op(input int n, input string name);
    int k = 0;
    while (Busy && k < 40) begin
      k++;
      @(negedge clk); #1;
    end
    check(name, 32'(k), 32'(n));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 0;
    check("rst_hi", HI, 0); check("rst_lo", LO, 0);
    check("rst_busy", 32'(Busy), 0); check("rst_mdout", MDOut, 0);
    start_op(3'd1, 32'hFFFFFFFF, 32'h2);
    finish_op(MC, "mult_busy_cycles");
    check("mult_hi", HI, 32'hFFFFFFFF); check("mult_lo", LO, 32'hFFFFFFFE);
    start_op(3'd2, 32'hFFFFFFFF, 32'h2);
    finish_op(MC, "multu_busy_cycles");
    ReadHI = 1;
    #1 check("multu_mdout_hi", MDOut, 32'h1);
    check("multu_lo", LO, 32'hFFFFFFFE);
    start_op(3'd3, 32'hFFFFFFF9, 32'h2);
    finish_op(DC, "div_busy_cycles");
    check("div_lo", LO, 32'hFFFFFFFD); check("div_hi", HI, 32'hFFFFFFFF);
    start_op(3'd4, 32'd7, 32'd2);
    finish_op(DC, "divu_busy_cycles");
    check("divu_lo", LO, 32'd3); check("divu_hi", HI, 32'd1);
    MDOp = 3'd5; A = 32'h12345678;
    @(negedge clk); #1 MDOp = 0;
    check("mthi", HI, 32'h12345678);
    start_op(3'd4, 32'd5, 32'd0);
    MDOp = 3'd6; A = 32'hCAFEF00D;
    @(negedge clk); #1 MDOp = 0;
    finish_op(DC - 1, "div0_busy_cycles");
    check("div0_hi", HI, 32'h12345678); check("div0_lo", LO, 32'd3);
    start_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    finish_op(DC, "divovf_busy_cycles");
    check("divovf_lo", LO, 32'h80000000); check("divovf_hi", HI, 32'h0);
    start_op(3'd1, 32'd3, 32'd5);
    repeat (2) begin @(negedge clk); #1; end
    check("busy_before_reset", 32'(Busy), 1);
    reset = 1;
    #1 check("async_rst_busy", 32'(Busy), 0);
    check("async_rst_hi", HI, 0); check("async_rst_lo", LO, 0);
    @(negedge clk); #1 reset = 0;
    repeat (12) @(negedge clk);
    #1 check("post_rst_lo", LO, 0); check("post_rst_busy", 32'(Busy), 0);
    start_op(3'd1, 32'd3, 32'd5);
    finish_op(MC, "b2b_mult_cycles");
    ReadHI = 0;
    start_op(3'd3, 32'd100, 32'd7);
    check("b2b_mdout_during_div", MDOut, 32'd15);
    finish_op(DC, "b2b_div_cycles");
    check("b2b_div_lo", LO, 32'd14); check("b2b_div_hi", HI, 32'd2);
    repeat (3000) begin
      @(negedge clk); #1;
      Start = $urandom_range(0, 2) == 0;
      MDOp = 3'($urandom_range(0, 7));
      A = $urandom;
      case ($urandom_range(0, 7))
        0: B = 0;
        1: begin A = 32'h80000000; B = 32'hFFFFFFFF; end
        2: B = $urandom_range(1, 9);
        default: B = $urandom;
      endcase
      ReadHI = 1'($urandom_range(0, 1));
    end
    Start = 0; MDOp = 0;
    repeat (15) @(negedge clk);
    #1 $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
